// File: rtl/inv_bist_pkg.sv
// Shared types and constants for the inverter-cell BIST controller.
package inv_bist_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  // Taps expressed as the state bits XORed into the new MSB.
  localparam int unsigned        LFSR_W        = 16;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS     = 16'h002D;
  localparam logic [LFSR_W-1:0]  LFSR_SEED_DEF = 16'hACE1;

  // Feedback bit for one shift of the stimulus LFSR.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/inv_bist_lfsr.sv
// Stimulus LFSR for the inverter BIST: load takes priority over shift.
module inv_bist_lfsr
  import inv_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next LFSR value: reload seed, advance one step, or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (shift) begin
      lfsr_d = {lfsr_fb(lfsr_q), lfsr_q[LFSR_W-1:1]};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/inv_bist_ctrl.sv
// BIST controller for the inverter test cell: drives LFSR stimulus on dut_a,
// resynchronises dut_y, compares against ~dut_a and counts mismatches.
// Optional macro INV_BIST_FIRST_FAIL_EN adds first-failure index capture.
module inv_bist_ctrl
  import inv_bist_pkg::*;
#(
  parameter int unsigned       NUM_W       = 16,
  parameter int unsigned       ERR_W       = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_vectors,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef INV_BIST_FIRST_FAIL_EN
  ,
  output logic [NUM_W-1:0] first_fail_idx,
  output logic             first_fail_vld
`endif
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 1..4");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   remaining_q, remaining_d;
  logic               dut_a_q, dut_a_d;
  logic               a_vld_q, a_vld_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] exp_q, exp_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               accept;
  logic               lfsr_load;
  logic               lfsr_shift;
  logic [LFSR_W-1:0]  lfsr_val;
  logic               cmp_vld;
  logic               mismatch;

  inv_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .shift (lfsr_shift),
    .q     (lfsr_val)
  );

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign cmp_vld  = vld_q[SYNC_STAGES-1];
  assign mismatch = cmp_vld && (sync_q[SYNC_STAGES-1] != exp_q[SYNC_STAGES-1]);

  // Sequencing: remaining counts issued bits in RUN, then is reused as the
  // drain timer (loaded with SYNC_STAGES, exits at zero -> SYNC_STAGES+1 cycles).
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lfsr_load   = 1'b0;
    lfsr_shift  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (num_vectors != '0) begin
            state_d     = RUN;
            remaining_d = num_vectors;
            lfsr_load   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        lfsr_shift  = 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == NUM_W'(1)) begin
          state_d     = DRAIN;
          remaining_d = NUM_W'(SYNC_STAGES);
        end
      end
      DRAIN: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          remaining_d = remaining_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stimulus, resync/expected pipelines, error counter and status outputs.
  // Status flags are registered from the current state, so they trail it by one cycle.
  always_comb begin
    dut_a_d  = (state_q == RUN) ? lfsr_val[0] : dut_a_q;
    a_vld_d  = (state_q == RUN);
    sync_d   = '0;
    exp_d    = '0;
    vld_d    = '0;
    sync_d[0] = dut_y;
    exp_d[0]  = ~dut_a_q;
    vld_d[0]  = a_vld_q;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
      exp_d[i]  = exp_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
    err_d = err_q;
    if (accept) begin
      err_d = '0;
    end else if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
    busy_d = (state_q == RUN) || (state_q == DRAIN);
    done_d = !accept && (state_q == DONE);
    pass_d = !accept && (state_q == DONE) && (err_q == '0);
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dut_a_q     <= 1'b0;
      a_vld_q     <= 1'b0;
      sync_q      <= '0;
      exp_q       <= '0;
      vld_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dut_a_q     <= dut_a_d;
      a_vld_q     <= a_vld_d;
      sync_q      <= sync_d;
      exp_q       <= exp_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef INV_BIST_FIRST_FAIL_EN
  logic [NUM_W-1:0] chk_idx_q, chk_idx_d;
  logic [NUM_W-1:0] ff_idx_q, ff_idx_d;
  logic             ff_vld_q, ff_vld_d;

  // Index of each compared sample; capture it on the first mismatch of a run.
  always_comb begin
    chk_idx_d = chk_idx_q;
    ff_idx_d  = ff_idx_q;
    ff_vld_d  = ff_vld_q;
    if (accept) begin
      chk_idx_d = '0;
      ff_idx_d  = '0;
      ff_vld_d  = 1'b0;
    end else begin
      if (cmp_vld) begin
        chk_idx_d = chk_idx_q + 1'b1;
      end
      if (mismatch && !ff_vld_q) begin
        ff_idx_d = chk_idx_q;
        ff_vld_d = 1'b1;
      end
    end
  end

  // First-failure capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_idx_q <= '0;
      ff_idx_q  <= '0;
      ff_vld_q  <= 1'b0;
    end else begin
      chk_idx_q <= chk_idx_d;
      ff_idx_q  <= ff_idx_d;
      ff_vld_q  <= ff_vld_d;
    end
  end

  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_inv_bist_ctrl.sv
// Directed self-checking bench for inv_bist_ctrl (SYNC_STAGES=2, ERR_W=8).
module tb_inv_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic        dut_a;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
`ifdef INV_BIST_FIRST_FAIL_EN
  logic [15:0] first_fail_idx;
  logic        first_fail_vld;
`endif

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int start_e = 0;
  int flip_e  = -100;
  int mode    = 0; // 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 good with one flipped vector

  inv_bist_ctrl #(
    .NUM_W       (16),
    .ERR_W       (8),
    .SYNC_STAGES (2),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .dut_a       (dut_a),
    .dut_y       (dut_y),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count)
`ifdef INV_BIST_FIRST_FAIL_EN
    ,
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Cell model.
  always_comb begin
    case (mode)
      1:       dut_y = 1'b0;
      2:       dut_y = 1'b1;
      3:       dut_y = ~dut_a ^ (ecnt == flip_e);
      default: dut_y = ~dut_a;
    endcase
  end

  // Returns at the negedge following the accepted start edge.
  task automatic pulse_start(input logic [15:0] n);
    @(negedge clk);
    start       = 1'b1;
    num_vectors = n;
    start_e     = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts rising edges after the start edge until done or limit.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dut_a, busy, done, pass, err_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got a=%b busy=%b done=%b pass=%b err=%0d, want all 0",
               dut_a, busy, done, pass, err_count);
    end
`ifdef INV_BIST_FIRST_FAIL_EN
    checks++;
    if (first_fail_vld !== 1'b0 || first_fail_idx !== 16'd0) begin
      errors++;
      $display("FAIL reset_first_fail: got vld=%b idx=%0d, want 0/0", first_fail_vld, first_fail_idx);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero_then_four;
    int cyc;
    mode = 0;
    pulse_start(16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0 || dut_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_vectors: got done=%b pass=%b err=%0d a=%b, want 1 1 0 0",
               done, pass, err_count, dut_a);
    end
    pulse_start(16'd4);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL four_latency: got %0d cycles, want 8", cyc);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL four_result: got pass=%b err=%0d, want 1 0", pass, err_count);
    end
  endtask

  task automatic test_good_100;
    int cyc, busy_cnt, a_bad;
    logic [15:0] m;
    logic fb;
    mode = 0;
    pulse_start(16'd100);
    cyc = 0; busy_cnt = 0; a_bad = 0; m = 16'hACE1;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) busy_cnt++;
      if (cyc <= 40) begin
        if (dut_a !== m[0]) a_bad++;
        fb = m[0] ^ m[2] ^ m[3] ^ m[5];
        m  = {fb, m[15:1]};
      end
      // Start while busy must be ignored.
      if (cyc == 50) begin start = 1'b1; num_vectors = 16'd3; end
      if (cyc == 51) start = 1'b0;
    end
    checks++;
    if (cyc !== 104) begin
      errors++;
      $display("FAIL good_done_latency: got %0d cycles, want 104", cyc);
    end
    checks++;
    if (busy_cnt !== 103) begin
      errors++;
      $display("FAIL good_busy_cycles: got %0d, want 103", busy_cnt);
    end
    checks++;
    if (a_bad !== 0) begin
      errors++;
      $display("FAIL lfsr_stream: got %0d wrong dut_a bits, want 0", a_bad);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_result: got pass=%b err=%0d busy=%b, want 1 0 0", pass, err_count, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: got done=%b pass=%b, want 1 1", done, pass);
    end
  endtask

  task automatic test_stuck0;
    int cyc;
    mode = 1;
    pulse_start(16'd16);
    wait_done(100, cyc);
    checks++;
    if (cyc !== 20) begin
      errors++;
      $display("FAIL stuck0_latency: got %0d cycles, want 20", cyc);
    end
    // 16'hACE1 holds eight zero bits.
    checks++;
    if (err_count !== 8'd8 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck0_result: got err=%0d pass=%b, want 8 0", err_count, pass);
    end
  endtask

  task automatic test_stuck1_sat;
    int cyc;
    mode = 2;
    pulse_start(16'd1000);
    wait_done(2000, cyc);
    checks++;
    if (cyc !== 1004) begin
      errors++;
      $display("FAIL stuck1_latency: got %0d cycles, want 1004", cyc);
    end
    checks++;
    if (err_count !== 8'd255 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck1_saturate: got err=%0d pass=%b, want 255 0", err_count, pass);
    end
    mode = 0;
  endtask

  task automatic test_rst_midrun;
    int cyc;
    mode = 1;
    pulse_start(16'd50);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dut_a, busy, done, pass, err_count} !== 12'h000) begin
      errors++;
      $display("FAIL rst_abort: got a=%b busy=%b done=%b pass=%b err=%0d, want all 0",
               dut_a, busy, done, pass, err_count);
    end
    rst  = 1'b0;
    mode = 0;
    pulse_start(16'd5);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 9 || pass !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_recover: got cyc=%0d pass=%b err=%0d, want 9 1 0", cyc, pass, err_count);
    end
  endtask

`ifdef INV_BIST_FIRST_FAIL_EN
  task automatic test_first_fail;
    int cyc;
    mode = 3;
    pulse_start(16'd20);
    flip_e = start_e + 8;
    wait_done(100, cyc);
    checks++;
    if (first_fail_vld !== 1'b1 || first_fail_idx !== 16'd7 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL first_fail: got vld=%b idx=%0d err=%0d, want 1 7 1",
               first_fail_vld, first_fail_idx, err_count);
    end
    flip_e = -100;
    mode   = 0;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_vectors = '0;
    test_reset();
    test_zero_then_four();
    test_good_100();
    test_stuck0();
    test_stuck1_sat();
    test_rst_midrun();
`ifdef INV_BIST_FIRST_FAIL_EN
    test_first_fail();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_bist_ctrl.md
Name: inv_bist_ctrl

Overview:
- Built-in self-test controller wrapped around the inverter test cell.
- Upstream side: drives the cell input with a pseudo-random bit stream.
- Downstream side: resynchronises the cell output, checks it against the inverted stimulus, and reports pass/fail with an error count.
- Lets silicon bring-up exercise the custom cell from a single start pulse.

Parameters:
- NUM_W, 16: width of the vector-count request.
- ERR_W, 8: width of the error counter (saturating).
- SYNC_STAGES, 2: flops on dut_y before compare. Legal range is 1..4.
- LFSR_SEED, 16'hACE1: LFSR load value at start. Must be nonzero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a test. Ignored unless state is IDLE or DONE.
- num_vectors  input  NUM_W  number of stimulus bits to issue. Latched on an accepted start.
- dut_a  output  1  registered drive to the cell input A.
- dut_y  input  1  cell output Y, treated as asynchronous.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE. Held until the next accepted start or rst.
- pass  output  1  valid while done=1. Equals 1 when err_count==0.
- err_count  output  ERR_W  number of mismatches; saturates at all-ones.

Behaviour:
- Reset values: dut_a=0, busy=0, done=0, pass=0, err_count=0, state=IDLE, LFSR=LFSR_SEED, sync and expected pipelines all 0.
- rst has priority over everything. Asserting it mid-test aborts to the reset values at the next edge; no partial result is retained.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts once per RUN cycle. dut_a is registered from the LFSR LSB.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start, num_vectors>0 → RUN. Loads LFSR_SEED and remaining=num_vectors; clears err_count, done and pass.
  - IDLE/DONE + start, num_vectors==0 → DONE next cycle with pass=1, err_count=0.
  - RUN: each cycle one bit is presented on dut_a and remaining is decremented. When the last bit is issued (remaining==1) → DRAIN.
  - DRAIN: lasts SYNC_STAGES+1 cycles, then → DONE. dut_a holds its last value.
  - DONE: done=1 and pass=(err_count==0). A new start restarts the test (same cycle rules as IDLE).
- Check path:
  - dut_y passes through SYNC_STAGES flops to give y_s.
  - In parallel, expected = ~dut_a is delayed through a SYNC_STAGES-deep shift register with a matching valid bit.
  - A sample is compared only when its valid bit is set. Valid is set for exactly num_vectors samples.
  - Mismatch → err_count+1, unless err_count is already all-ones (saturate, no wrap).
- Latency: stimulus bit k appears on dut_a one cycle after it is issued and is checked SYNC_STAGES cycles later. done rises exactly num_vectors + SYNC_STAGES + 2 cycles after the accepted start edge.
- A start while busy=1 is ignored; no state changes.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro: INV_BIST_FIRST_FAIL_EN.
- Defined:
  - Adds output first_fail_idx [NUM_W-1:0] and output first_fail_vld [1].
  - On the first mismatch of a run, records the 0-based vector index and sets vld.
  - Both are cleared on rst and on an accepted start.
- Undefined: neither port nor its logic exists. Behaviour is otherwise identical.

Decomposition:
- Package inv_bist_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - LFSR width and tap constant;
  - the default seed.
- One sub-module, inv_bist_lfsr, with ports clk, rst, load, shift, q. The FSM, sync chain, compare and counter remain in inv_bist_ctrl.

Test Plan:
- Good cell (bench models Y=~A), SYNC_STAGES=2, start with num_vectors=100 → busy 100+3 cycles, done at cycle 104, pass=1, err_count=0.
- Stuck-at-0 cell (Y=0) with num_vectors=16 → err_count equals the number of zeros in the first 16 LFSR bits from seed 16'hACE1; pass=0.
- Stuck-at-1 cell with num_vectors=1000 and ERR_W=8 → err_count saturates at 255, no wrap; pass=0.
- num_vectors=0 → done=1 the cycle after start, pass=1, dut_a stays 0. Then start again with 4 on a good cell → pass=1, err_count=0.
- rst asserted in RUN cycle 10 of 50 → all outputs at reset values next cycle. A following start with 5 completes normally.
- With INV_BIST_FIRST_FAIL_EN defined, bench flips Y on vector index 7 only → first_fail_vld=1, first_fail_idx=7, err_count=1.
